// File: rtl/bomb_manager.sv
// rtl/bomb_manager.sv - bomb slot lifecycle: placement, fuse, blast, chain reaction, stun
//
// Ports:
//   clock, Reset          rising-edge clock, synchronous active-low reset
//   tick                  game-tick enable for fuse/blast counters
//   bombRequestP1/P2      player bomb request levels (rising edge acted on)
//   p1X/p1Y, p2X/p2Y      player grid positions (6 bits, valid cells 0..15)
//   bombAcceptedP1/P2     one-cycle pulse when a request took a slot
//   stunnedP1/P2          player inside a live blast (registered)
//   activeCount           number of non-idle slots (registered)
//   querySlot             renderer slot index
//   slotState/slotX/slotY combinational view of the queried slot
module bomb_manager #(
  parameter int MAX_BOMBS    = 4,
  parameter int FUSE_TICKS   = 48,
  parameter int BLAST_TICKS  = 8,
  parameter int BLAST_RADIUS = 2
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       tick,
  input  logic       bombRequestP1,
  input  logic [5:0] p1X,
  input  logic [5:0] p1Y,
  input  logic       bombRequestP2,
  input  logic [5:0] p2X,
  input  logic [5:0] p2Y,
  output logic       bombAcceptedP1,
  output logic       bombAcceptedP2,
  output logic       stunnedP1,
  output logic       stunnedP2,
  output logic [3:0] activeCount,
  input  logic [2:0] querySlot,
  output logic [1:0] slotState,
  output logic [3:0] slotX,
  output logic [3:0] slotY
);

  localparam int CNT_MAX = (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FUSE  = 2'd1,
    S_BLAST = 2'd2
  } slot_state_t;

  slot_state_t       slot_state [MAX_BOMBS];
  logic [3:0]        slot_x     [MAX_BOMBS];
  logic [3:0]        slot_y     [MAX_BOMBS];
  logic [CNT_W-1:0]  slot_cnt   [MAX_BOMBS];

  slot_state_t       next_state [MAX_BOMBS];
  logic [3:0]        next_x     [MAX_BOMBS];
  logic [3:0]        next_y     [MAX_BOMBS];
  logic [CNT_W-1:0]  next_cnt   [MAX_BOMBS];

  logic prev_p1, prev_p2;
  logic req1, req2, ok_pos1, ok_pos2, dup1, dup2;
  logic found1, found2, valid1, valid2, same_cell;
  int   idx1, idx2;
  logic [MAX_BOMBS-1:0] chain_hit;
  logic stun1_next, stun2_next;
  logic [3:0] count_next;

  // Plus-shaped footprint test. Differences are 5-bit magnitudes so a blast
  // near one edge never reaches around to the opposite edge.
  function automatic logic covers(input logic [3:0] bx, input logic [3:0] by,
                                  input logic [5:0] px, input logic [5:0] py);
    logic [4:0] dx, dy;
    if (px > 6'd15 || py > 6'd15) return 1'b0;
    dx = (px[3:0] >= bx) ? ({1'b0, px[3:0]} - {1'b0, bx}) : ({1'b0, bx} - {1'b0, px[3:0]});
    dy = (py[3:0] >= by) ? ({1'b0, py[3:0]} - {1'b0, by}) : ({1'b0, by} - {1'b0, py[3:0]});
    return ((py[3:0] == by) && (dx <= 5'(BLAST_RADIUS))) ||
           ((px[3:0] == bx) && (dy <= 5'(BLAST_RADIUS)));
  endfunction

  always_comb begin
    req1       = bombRequestP1 & ~prev_p1;
    req2       = bombRequestP2 & ~prev_p2;
    ok_pos1    = (p1X <= 6'd15) && (p1Y <= 6'd15);
    ok_pos2    = (p2X <= 6'd15) && (p2Y <= 6'd15);
    same_cell  = (p1X == p2X) && (p1Y == p2Y);
    dup1       = 1'b0;
    dup2       = 1'b0;
    found1     = 1'b0;
    found2     = 1'b0;
    idx1       = 0;
    idx2       = 0;
    chain_hit  = '0;
    stun1_next = 1'b0;
    stun2_next = 1'b0;
    count_next = 4'd0;

    for (int i = 0; i < MAX_BOMBS; i++) begin
      if (slot_state[i] != S_IDLE) begin
        count_next = count_next + 4'd1;
        if ({2'b00, slot_x[i]} == p1X && {2'b00, slot_y[i]} == p1Y) dup1 = 1'b1;
        if ({2'b00, slot_x[i]} == p2X && {2'b00, slot_y[i]} == p2Y) dup2 = 1'b1;
      end
      if (slot_state[i] == S_IDLE && !found1) begin
        found1 = 1'b1;
        idx1   = i;
      end
    end
    valid1 = req1 && ok_pos1 && !dup1 && found1;

    // P2 searches above P1's slot only when P1 is actually allocating.
    for (int i = 0; i < MAX_BOMBS; i++) begin
      if (slot_state[i] == S_IDLE && !found2 && !(valid1 && i <= idx1)) begin
        found2 = 1'b1;
        idx2   = i;
      end
    end
    valid2 = req2 && ok_pos2 && !dup2 && found2 && !(valid1 && same_cell);

    for (int j = 0; j < MAX_BOMBS; j++) begin
      if (slot_state[j] == S_BLAST) begin
        if (covers(slot_x[j], slot_y[j], p1X, p1Y)) stun1_next = 1'b1;
        if (covers(slot_x[j], slot_y[j], p2X, p2Y)) stun2_next = 1'b1;
        for (int i = 0; i < MAX_BOMBS; i++) begin
          if (covers(slot_x[j], slot_y[j], {2'b00, slot_x[i]}, {2'b00, slot_y[i]}))
            chain_hit[i] = 1'b1;
        end
      end
    end

    for (int i = 0; i < MAX_BOMBS; i++) begin
      next_state[i] = slot_state[i];
      next_x[i]     = slot_x[i];
      next_y[i]     = slot_y[i];
      next_cnt[i]   = slot_cnt[i];
      if (tick) begin
        case (slot_state[i])
          S_FUSE: begin
            // A neighbouring blast detonates this bomb early, whatever its fuse.
            if (slot_cnt[i] == '0 || chain_hit[i]) begin
              next_state[i] = S_BLAST;
              next_cnt[i]   = CNT_W'(BLAST_TICKS - 1);
            end else begin
              next_cnt[i] = slot_cnt[i] - 1'b1;
            end
          end
          S_BLAST: begin
            if (slot_cnt[i] == '0) begin
              next_state[i] = S_IDLE;
            end else begin
              next_cnt[i] = slot_cnt[i] - 1'b1;
            end
          end
          default: ;
        endcase
      end
      // Allocation only targets slots that are IDLE now, so it never races
      // with the tick update above.
      if (valid1 && i == idx1) begin
        next_state[i] = S_FUSE;
        next_x[i]     = p1X[3:0];
        next_y[i]     = p1Y[3:0];
        next_cnt[i]   = CNT_W'(FUSE_TICKS - 1);
      end
      if (valid2 && i == idx2) begin
        next_state[i] = S_FUSE;
        next_x[i]     = p2X[3:0];
        next_y[i]     = p2Y[3:0];
        next_cnt[i]   = CNT_W'(FUSE_TICKS - 1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!Reset) begin
      for (int i = 0; i < MAX_BOMBS; i++) begin
        slot_state[i] <= S_IDLE;
        slot_x[i]     <= 4'd0;
        slot_y[i]     <= 4'd0;
        slot_cnt[i]   <= '0;
      end
      prev_p1        <= 1'b0;
      prev_p2        <= 1'b0;
      bombAcceptedP1 <= 1'b0;
      bombAcceptedP2 <= 1'b0;
      stunnedP1      <= 1'b0;
      stunnedP2      <= 1'b0;
      activeCount    <= 4'd0;
    end else begin
      for (int i = 0; i < MAX_BOMBS; i++) begin
        slot_state[i] <= next_state[i];
        slot_x[i]     <= next_x[i];
        slot_y[i]     <= next_y[i];
        slot_cnt[i]   <= next_cnt[i];
      end
      prev_p1        <= bombRequestP1;
      prev_p2        <= bombRequestP2;
      bombAcceptedP1 <= valid1;
      bombAcceptedP2 <= valid2;
      stunnedP1      <= stun1_next;
      stunnedP2      <= stun2_next;
      activeCount    <= count_next;
    end
  end

  always_comb begin
    slotState = 2'd0;
    slotX     = 4'd0;
    slotY     = 4'd0;
    for (int i = 0; i < MAX_BOMBS; i++) begin
      if (querySlot == 3'(i)) begin
        slotState = slot_state[i];
        slotX     = slot_x[i];
        slotY     = slot_y[i];
      end
    end
  end

endmodule

// File: tb/tb_bomb_manager.sv
// tb/tb_bomb_manager.sv - self-checking bench for bomb_manager
module tb_bomb_manager;

  logic       clock = 1'b0;
  logic       Reset;
  logic       tick;
  logic       bombRequestP1, bombRequestP2;
  logic [5:0] p1X, p1Y, p2X, p2Y;
  logic       bombAcceptedP1, bombAcceptedP2;
  logic       stunnedP1, stunnedP2;
  logic [3:0] activeCount;
  logic [2:0] querySlot;
  logic [1:0] slotState;
  logic [3:0] slotX, slotY;

  int checks = 0;
  int errors = 0;
  logic [1:0] sb [$];

  bomb_manager #(
    .MAX_BOMBS(4), .FUSE_TICKS(24), .BLAST_TICKS(2), .BLAST_RADIUS(2)
  ) dut (
    .clock(clock), .Reset(Reset), .tick(tick),
    .bombRequestP1(bombRequestP1), .p1X(p1X), .p1Y(p1Y),
    .bombRequestP2(bombRequestP2), .p2X(p2X), .p2Y(p2Y),
    .bombAcceptedP1(bombAcceptedP1), .bombAcceptedP2(bombAcceptedP2),
    .stunnedP1(stunnedP1), .stunnedP2(stunnedP2),
    .activeCount(activeCount), .querySlot(querySlot),
    .slotState(slotState), .slotX(slotX), .slotY(slotY)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_compare(input string tag);
    logic [1:0] exp;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = sb.pop_front();
      chk(tag, {30'd0, bombAcceptedP1, bombAcceptedP2}, {30'd0, exp});
    end
  endtask

  task automatic req_pulse(input logic r1, input logic r2, input logic e1, input logic e2,
                           input string tag);
    sb.push_back({e1, e2});
    sb.push_back(2'b00);
    bombRequestP1 = r1;
    bombRequestP2 = r2;
    step();
    sb_compare({tag, "_acc"});
    bombRequestP1 = 1'b0;
    bombRequestP2 = 1'b0;
    step();
    sb_compare({tag, "_acc_clear"});
  endtask

  task automatic run_ticks(input int n);
    tick = 1'b1;
    repeat (n) step();
    tick = 1'b0;
  endtask

  task automatic query(input int s, input int st, input int x, input int y, input string tag);
    querySlot = 3'(s);
    #1;
    chk({tag, "_state"}, {30'd0, slotState}, st);
    if (st != 0) begin
      chk({tag, "_x"}, {28'd0, slotX}, x);
      chk({tag, "_y"}, {28'd0, slotY}, y);
    end
  endtask

  task automatic set_pos(input int ax, input int ay, input int bx, input int by);
    p1X = 6'(ax); p1Y = 6'(ay); p2X = 6'(bx); p2Y = 6'(by);
  endtask

  initial begin
    Reset = 1'b0; tick = 1'b0; bombRequestP1 = 1'b0; bombRequestP2 = 1'b0;
    querySlot = 3'd0;
    set_pos(3, 4, 12, 12);
    step(); step();
    Reset = 1'b1;
    chk("rst_acc1", {31'd0, bombAcceptedP1}, 0);
    chk("rst_acc2", {31'd0, bombAcceptedP2}, 0);
    chk("rst_stun1", {31'd0, stunnedP1}, 0);
    chk("rst_stun2", {31'd0, stunnedP2}, 0);
    chk("rst_count", {28'd0, activeCount}, 0);
    query(0, 0, 0, 0, "rst_q0");

    // Placement, fuse, blast and stun timing
    req_pulse(1'b1, 1'b0, 1'b1, 1'b0, "place");
    chk("place_count", {28'd0, activeCount}, 1);
    query(0, 1, 3, 4, "place_q0");
    set_pos(5, 4, 12, 12);
    run_ticks(23);
    query(0, 1, 3, 4, "fuse_last");
    tick = 1'b1;
    step();
    query(0, 2, 3, 4, "detonate");
    chk("stun_lag", {31'd0, stunnedP1}, 0);
    step();
    chk("stun_c1", {31'd0, stunnedP1}, 1);
    chk("stun_p2_far", {31'd0, stunnedP2}, 0);
    query(0, 2, 3, 4, "blast_c1");
    step();
    chk("stun_c2", {31'd0, stunnedP1}, 1);
    query(0, 0, 0, 0, "blast_end");
    tick = 1'b0;
    step();
    chk("stun_off", {31'd0, stunnedP1}, 0);
    chk("idle_count", {28'd0, activeCount}, 0);

    // Radius bound around a corner blast
    set_pos(0, 0, 2, 0);
    req_pulse(1'b1, 1'b0, 1'b1, 1'b0, "corner");
    run_ticks(24);
    query(0, 2, 0, 0, "corner_blast");
    step();
    chk("rad_2_0", {31'd0, stunnedP2}, 1);
    chk("rad_self", {31'd0, stunnedP1}, 1);
    set_pos(0, 0, 3, 0); step();
    chk("rad_3_0", {31'd0, stunnedP2}, 0);
    set_pos(0, 0, 1, 1); step();
    chk("rad_1_1", {31'd0, stunnedP2}, 0);
    set_pos(0, 0, 0, 15); step();
    chk("rad_nowrap", {31'd0, stunnedP2}, 0);
    set_pos(0, 0, 0, 2); step();
    chk("rad_0_2", {31'd0, stunnedP2}, 1);
    set_pos(12, 12, 13, 13);
    run_ticks(2);
    step();
    chk("corner_idle", {28'd0, activeCount}, 0);

    // Simultaneous, duplicate and full
    set_pos(7, 7, 7, 7);
    req_pulse(1'b1, 1'b1, 1'b1, 1'b0, "same_cell");
    chk("same_count", {28'd0, activeCount}, 1);
    req_pulse(1'b0, 1'b1, 1'b0, 1'b0, "dup");
    set_pos(7, 7, 1, 1);
    req_pulse(1'b0, 1'b1, 1'b0, 1'b1, "p2_alone");
    set_pos(2, 2, 1, 1);
    req_pulse(1'b1, 1'b0, 1'b1, 1'b0, "fill2");
    set_pos(3, 3, 4, 4);
    req_pulse(1'b1, 1'b1, 1'b1, 1'b0, "one_free");
    chk("full_count", {28'd0, activeCount}, 4);
    set_pos(9, 9, 4, 4);
    req_pulse(1'b1, 1'b0, 1'b0, 1'b0, "fifth");
    set_pos(2, 2, 4, 4);
    req_pulse(1'b1, 1'b0, 1'b0, 1'b0, "dup_full");
    query(0, 1, 7, 7, "full_q0");
    query(1, 1, 1, 1, "full_q1");
    query(2, 1, 2, 2, "full_q2");
    query(3, 1, 3, 3, "full_q3");
    query(5, 0, 0, 0, "q_oob");
    chk("full_count2", {28'd0, activeCount}, 4);
    set_pos(12, 12, 13, 13);
    run_ticks(26);
    step();
    chk("clear_count", {28'd0, activeCount}, 0);

    // Chain reaction
    set_pos(5, 5, 13, 13);
    req_pulse(1'b1, 1'b0, 1'b1, 1'b0, "chain_a");
    run_ticks(20);
    set_pos(6, 5, 13, 13);
    req_pulse(1'b1, 1'b0, 1'b1, 1'b0, "chain_b");
    run_ticks(3);
    query(1, 1, 6, 5, "chain_b_fuse");
    tick = 1'b1;
    step();
    query(0, 2, 5, 5, "chain_a_blast");
    query(1, 1, 6, 5, "chain_b_wait");
    step();
    query(1, 2, 6, 5, "chain_b_blast");
    tick = 1'b0;
    step();
    chk("chain_stun", {31'd0, stunnedP1}, 1);
    chk("chain_count", {28'd0, activeCount}, 2);

    // Reset mid-blast
    Reset = 1'b0;
    step();
    Reset = 1'b1;
    chk("midrst_stun", {31'd0, stunnedP1}, 0);
    chk("midrst_count", {28'd0, activeCount}, 0);
    query(0, 0, 0, 0, "midrst_q0");
    step();

    // Out-of-grid request and held level
    set_pos(20, 0, 13, 13);
    req_pulse(1'b1, 1'b0, 1'b0, 1'b0, "x20");
    set_pos(8, 8, 13, 13);
    bombRequestP1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      sb.push_back((k == 0) ? 2'b10 : 2'b00);
      step();
      sb_compare("level_held");
    end
    bombRequestP1 = 1'b0;
    step();
    chk("level_count", {28'd0, activeCount}, 1);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
